// File: rtl/calc_display_driver_if.sv
// Handshake and display bus for calc_display_driver.
// The master side supplies the value and its load strobe. The slave side
// returns ready, the BCD result and the multiplexed seven-segment drive.
interface calc_display_driver_if;
    logic [7:0]  value;
    logic        value_valid;
    logic        ready;
    logic [11:0] bcd_out;
    logic [2:0]  an;
    logic [6:0]  seg;

    modport master (
        output value,
        output value_valid,
        input  ready,
        input  bcd_out,
        input  an,
        input  seg
    );

    modport slave (
        input  value,
        input  value_valid,
        output ready,
        output bcd_out,
        output an,
        output seg
    );
endinterface

// File: rtl/calc_display_driver.sv
// calc_display_driver: converts an 8-bit value to three BCD digits with a
// sequential double-dabble engine (8 shift cycles, 9-clock latency). It then
// scans the digits onto an active-low seven-segment display.
// A strobe that arrives while busy is held in a one-deep pending register,
// and the latest strobe wins.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module calc_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    calc_display_driver_if.slave  bus
);
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [7:0]         bin_q, bin_d;
    logic [11:0]        acc_q, acc_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         pend_val_q, pend_val_d;
    logic               pend_flag_q, pend_flag_d;
    logic               ready_q, ready_d;
    logic [11:0]        bcd_out_q, bcd_out_d;
    logic [11:0]        disp_q, disp_d;
    logic [CNT_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [2:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    // One double-dabble step: add 3 to each nibble >= 5, then shift {acc, bin} left.
    logic [11:0] acc_adj;
    logic [19:0] shift_w;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                        acc_q[gi*4 +: 4] + 4'd3 : acc_q[gi*4 +: 4];
        end
    endgenerate

    assign shift_w = {acc_adj[10:0], bin_q, 1'b0};

    // Digit decoder; bit order is g..a and the segments are active low.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Conversion FSM next-state logic, including pending capture and result load.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        bit_cnt_d   = bit_cnt_q;
        pend_val_d  = pend_val_q;
        pend_flag_d = pend_flag_q;
        ready_d     = ready_q;
        bcd_out_d   = bcd_out_q;
        disp_d      = disp_q;

        case (state_q)
            IDLE: begin
                if (bus.value_valid && ready_q) begin
                    bin_d     = bus.value;
                    acc_d     = 12'd0;
                    bit_cnt_d = 3'd0;
                    ready_d   = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                acc_d     = shift_w[19:8];
                bin_d     = shift_w[7:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_out_d = acc_q;
                disp_d    = acc_q;
                if (pend_flag_q) begin
                    bin_d       = pend_val_q;
                    acc_d       = 12'd0;
                    bit_cnt_d   = 3'd0;
                    pend_flag_d = 1'b0;
                    state_d     = SHIFT;
                end else begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase

        // A strobe while busy is parked; it overrides the clear done in DONE.
        if (bus.value_valid && !ready_q) begin
            pend_val_d  = bus.value;
            pend_flag_d = 1'b1;
        end
    end

    // Free-running scan counter and digit select, plus the registered an/seg drive.
    always_comb begin
        logic [3:0] digit;
        logic       blank;

        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        digit = 4'd0;
        blank = 1'b0;
        an_d  = 3'b111;
        case (idx_q)
            2'd0: begin
                digit = disp_q[3:0];
                an_d  = 3'b110;
            end
            2'd1: begin
                digit = disp_q[7:4];
                an_d  = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
`endif
            end
            2'd2: begin
                digit = disp_q[11:8];
                an_d  = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
                blank = (disp_q[11:8] == 4'd0);
`endif
            end
            default: begin
                blank = 1'b1;
            end
        endcase

        if (blank) begin
            an_d  = 3'b111;
            seg_d = 7'b1111111;
        end else begin
            seg_d = seg_decode(digit);
        end
    end

    // All state registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bin_q       <= 8'd0;
            acc_q       <= 12'd0;
            bit_cnt_q   <= 3'd0;
            pend_val_q  <= 8'd0;
            pend_flag_q <= 1'b0;
            ready_q     <= 1'b1;
            bcd_out_q   <= 12'd0;
            disp_q      <= 12'd0;
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            an_q        <= 3'b111;
            seg_q       <= 7'b1111111;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            bit_cnt_q   <= bit_cnt_d;
            pend_val_q  <= pend_val_d;
            pend_flag_q <= pend_flag_d;
            ready_q     <= ready_d;
            bcd_out_q   <= bcd_out_d;
            disp_q      <= disp_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.bcd_out = bcd_out_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
endmodule

// File: tb/tb_calc_display_driver.sv
// Directed testbench for calc_display_driver with REFRESH_DIV = 4.
module tb_calc_display_driver;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    calc_display_driver_if bus_if ();

    calc_display_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] SEG0 = 7'b1000000;
    localparam logic [6:0] SEG2 = 7'b0100100;
    localparam logic [6:0] SEG5 = 7'b0010010;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int max_cycles);
        int n;
        n = 0;
        while (bus_if.ready !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        if (bus_if.ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_an(input logic [2:0] target, input int max_cycles);
        int n;
        n = 0;
        while (bus_if.an !== target && n < max_cycles) begin
            tick();
            n++;
        end
        if (bus_if.an !== target) chk("an_timeout", {29'd0, bus_if.an}, {29'd0, target});
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus_if.value = 8'd0;
        bus_if.value_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", {31'd0, bus_if.ready}, 32'd1);
        chk("rst_bcd", {20'd0, bus_if.bcd_out}, 32'd0);
        chk("rst_an", {29'd0, bus_if.an}, 32'b111);
        chk("rst_seg", {25'd0, bus_if.seg}, {25'd0, SEG_OFF});
        #2 rst_n = 1'b1;

        // Scan pattern with no load: each digit lit for 4 clocks
        for (int i = 0; i < 13; i++) begin
            tick();
            case ((i / 4) % 3)
                0: begin exp_an = 3'b110; exp_seg = SEG0; end
                1: begin exp_an = 3'b101; exp_seg = SEG0; end
                default: begin exp_an = 3'b011; exp_seg = SEG0; end
            endcase
`ifdef LEADING_ZERO_BLANK_EN
            if (exp_an != 3'b110) begin exp_an = 3'b111; exp_seg = SEG_OFF; end
`endif
            chk("scan_an", {29'd0, bus_if.an}, {29'd0, exp_an});
            chk("scan_seg", {25'd0, bus_if.seg}, {25'd0, exp_seg});
            $display("scan cycle %0d an=%b seg=%b", i, bus_if.an, bus_if.seg);
        end

        // value = 255: ready low for E0..E8, result on E9
        bus_if.value = 8'd255;
        bus_if.value_valid = 1'b1;
        tick();
        bus_if.value_valid = 1'b0;
        chk("v255_ready_e0", {31'd0, bus_if.ready}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("v255_ready_busy", {31'd0, bus_if.ready}, 32'd0);
            if (k == 8) chk("v255_bcd_e8", {20'd0, bus_if.bcd_out}, 32'd0);
        end
        tick();
        chk("v255_ready_e9", {31'd0, bus_if.ready}, 32'd1);
        chk("v255_bcd_e9", {20'd0, bus_if.bcd_out}, 32'h255);
        $display("convert 255 bcd_out=%h ready=%b", bus_if.bcd_out, bus_if.ready);
        tick();
        wait_an(3'b110, 20);
        chk("v255_seg_ones", {25'd0, bus_if.seg}, {25'd0, SEG5});
        wait_an(3'b101, 20);
        chk("v255_seg_tens", {25'd0, bus_if.seg}, {25'd0, SEG5});
        wait_an(3'b011, 20);
        chk("v255_seg_hund", {25'd0, bus_if.seg}, {25'd0, SEG2});

        // Full sweep 0..255
        for (int v = 0; v < 256; v++) begin
            wait_ready(20);
            bus_if.value = 8'(v);
            bus_if.value_valid = 1'b1;
            tick();
            bus_if.value_valid = 1'b0;
            tick();
            wait_ready(20);
            chk("sweep_bcd", {20'd0, bus_if.bcd_out}, {20'd0, to_bcd(v)});
            $display("sweep value=%0d bcd_out=%h", v, bus_if.bcd_out);
        end

        // Pending: 7 at E0, 199 at E3, 200 at E5; 200 wins
        bus_if.value = 8'd7;
        bus_if.value_valid = 1'b1;
        tick();                                  // E0
        bus_if.value_valid = 1'b0;
        tick();                                  // E1
        tick();                                  // E2
        bus_if.value = 8'd199;
        bus_if.value_valid = 1'b1;
        tick();                                  // E3
        bus_if.value_valid = 1'b0;
        tick();                                  // E4
        bus_if.value = 8'd200;
        bus_if.value_valid = 1'b1;
        tick();                                  // E5
        bus_if.value_valid = 1'b0;
        repeat (3) tick();                       // E8
        chk("pend_bcd_e8", {20'd0, bus_if.bcd_out}, 32'h255);
        tick();                                  // E9
        chk("pend_bcd_e9", {20'd0, bus_if.bcd_out}, 32'h007);
        chk("pend_ready_e9", {31'd0, bus_if.ready}, 32'd0);
        $display("pending E9 bcd_out=%h ready=%b", bus_if.bcd_out, bus_if.ready);
        for (int k = 10; k <= 17; k++) begin
            tick();
            chk("pend_bcd_hold", {20'd0, bus_if.bcd_out}, 32'h007);
            chk("pend_ready_busy", {31'd0, bus_if.ready}, 32'd0);
        end
        tick();                                  // E18
        chk("pend_bcd_e18", {20'd0, bus_if.bcd_out}, 32'h200);
        chk("pend_ready_e18", {31'd0, bus_if.ready}, 32'd1);
        $display("pending E18 bcd_out=%h ready=%b", bus_if.bcd_out, bus_if.ready);

        // Reset during conversion of 99
        bus_if.value = 8'd99;
        bus_if.value_valid = 1'b1;
        tick();                                  // E0
        bus_if.value_valid = 1'b0;
        repeat (3) tick();                       // E3
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_bcd", {20'd0, bus_if.bcd_out}, 32'd0);
        chk("rst_mid_an", {29'd0, bus_if.an}, 32'b111);
        chk("rst_mid_seg", {25'd0, bus_if.seg}, {25'd0, SEG_OFF});
        chk("rst_mid_ready", {31'd0, bus_if.ready}, 32'd1);
        tick();
        tick();
        chk("rst_hold_an", {29'd0, bus_if.an}, 32'b111);
        chk("rst_hold_bcd", {20'd0, bus_if.bcd_out}, 32'd0);
        #2 rst_n = 1'b1;
        chk("rst_rel_ready", {31'd0, bus_if.ready}, 32'd1);
        tick();
        chk("rst_rel_an", {29'd0, bus_if.an}, 32'b110);
        chk("rst_rel_seg", {25'd0, bus_if.seg}, {25'd0, SEG0});
        repeat (12) tick();
        chk("rst_rel_bcd", {20'd0, bus_if.bcd_out}, 32'd0);
        chk("rst_rel_ready2", {31'd0, bus_if.ready}, 32'd1);
        $display("reset mid-conversion bcd_out=%h ready=%b", bus_if.bcd_out, bus_if.ready);

`ifdef LEADING_ZERO_BLANK_EN
        // Leading zero blanking with value = 5
        bus_if.value = 8'd5;
        bus_if.value_valid = 1'b1;
        tick();
        bus_if.value_valid = 1'b0;
        tick();
        wait_ready(20);
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.an === 3'b110) begin
                chk("blank_ones_seg", {25'd0, bus_if.seg}, {25'd0, SEG5});
            end else begin
                chk("blank_an", {29'd0, bus_if.an}, 32'b111);
                chk("blank_seg", {25'd0, bus_if.seg}, {25'd0, SEG_OFF});
            end
        end
        $display("blanking value=5 checked");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
